// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default register-bank geometry, bank FSM states
// and the per-byte merge used by both the register write path and the read bypass.
package cpu_pkg;

   localparam int CPU_DATA_W   = 16;
   localparam int CPU_NUM_REGS = 8;

   typedef enum logic {
      IDLE,
      CLEAR
   } bank_state_e;

   function automatic logic [7:0] byte_merge(
      input logic [7:0] old_byte,
      input logic [7:0] new_byte,
      input logic       be
   );
      return be ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/cpu_reg_bank_if.sv
// Register-bank bus: bulk-clear control, handshaked write port and two read ports.
// The bank is the slave; the datapath/controller is the master.
interface cpu_reg_bank_if
   import cpu_pkg::*;
#(
   parameter int DATA_W   = CPU_DATA_W,
   parameter int NUM_REGS = CPU_NUM_REGS
);
   localparam int ADDR_W = $clog2(NUM_REGS);
   localparam int BE_W   = DATA_W / 8;

   logic              clr_req;
   logic              busy;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [BE_W-1:0]   wr_be;
   logic [ADDR_W-1:0] rd_addr_a;
   logic [DATA_W-1:0] rd_data_a;
   logic [ADDR_W-1:0] rd_addr_b;
   logic [DATA_W-1:0] rd_data_b;

   modport master (
      output clr_req, wr_valid, wr_addr, wr_data, wr_be, rd_addr_a, rd_addr_b,
      input  busy, wr_ready, rd_data_a, rd_data_b
   );

   modport slave (
      input  clr_req, wr_valid, wr_addr, wr_data, wr_be, rd_addr_a, rd_addr_b,
      output busy, wr_ready, rd_data_a, rd_data_b
   );

endinterface

// File: rtl/cpu_reg_clear_seq.sv
// Bulk-clear sequencer: on clr_req walks a counter over every register, one per cycle,
// then returns to IDLE. Requests arriving mid-sequence are ignored.
module cpu_reg_clear_seq
   import cpu_pkg::*;
#(
   parameter  int NUM_REGS = CPU_NUM_REGS,
   localparam int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_req,
   output logic              busy,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

   bank_state_e       state_reg, state_next;
   logic [ADDR_W-1:0] cnt_reg, cnt_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      busy       = 1'b0;
      clr_we     = 1'b0;
      clr_addr   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (clr_req) begin
               state_next = CLEAR;
               cnt_next   = '0;
            end
         end
         CLEAR: begin
            busy   = 1'b1;
            clr_we = 1'b1;
            // Leave before the counter would wrap; it parks on the last address.
            if (cnt_reg == LAST_ADDR) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg + ADDR_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: rtl/cpu_reg_bank.sv
// General-purpose register file: two combinational read ports, one byte-enabled handshaked
// write port and a sequenced bulk clear. Define CPU_REG_BANK_BYPASS_EN for write-to-read bypass.
module cpu_reg_bank
   import cpu_pkg::*;
#(
   parameter  int DATA_W   = CPU_DATA_W,
   parameter  int NUM_REGS = CPU_NUM_REGS,
   parameter  int R0_ZERO  = 0,
   localparam int ADDR_W   = $clog2(NUM_REGS),
   localparam int BE_W     = DATA_W / 8
) (
   input logic            clk,
   input logic            rst_n,
   cpu_reg_bank_if.slave  bus
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   logic              busy;
   logic              clr_we;
   logic [ADDR_W-1:0] clr_addr;
   logic              wr_fire;
   logic              wr_en;
   logic [DATA_W-1:0] wr_old;
   logic [DATA_W-1:0] wr_merged;

   cpu_reg_clear_seq #(
      .NUM_REGS (NUM_REGS)
   ) u_clear_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_req  (bus.clr_req),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign bus.busy     = busy;
   assign bus.wr_ready = ~busy;

   assign wr_fire = bus.wr_valid & ~busy;
   assign wr_en   = wr_fire & ~((R0_ZERO != 0) && (bus.wr_addr == '0));
   assign wr_old  = regs[bus.wr_addr];

   generate
      for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
         assign wr_merged[8*gi +: 8] = byte_merge(wr_old[8*gi +: 8],
                                                  bus.wr_data[8*gi +: 8],
                                                  bus.wr_be[gi]);
      end
   endgenerate

   // Clear and user write never collide: wr_ready is low whenever clr_we is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (clr_we) begin
         regs[clr_addr] <= '0;
      end else if (wr_en) begin
         regs[bus.wr_addr] <= wr_merged;
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         logic [ADDR_W-1:0] addr;
         logic [DATA_W-1:0] data;
         logic              hit;

         assign addr = (gi == 0) ? bus.rd_addr_a : bus.rd_addr_b;
`ifdef CPU_REG_BANK_BYPASS_EN
         assign hit = wr_fire && (bus.wr_addr == addr);
`else
         assign hit = 1'b0;
`endif
         always_comb begin
            if ((R0_ZERO != 0) && (addr == '0)) begin
               data = '0;
            end else if (hit) begin
               data = wr_merged;
            end else begin
               data = regs[addr];
            end
         end
      end
   endgenerate

   assign bus.rd_data_a = g_rd[0].data;
   assign bus.rd_data_b = g_rd[1].data;

endmodule
